// File: rtl/accel_job_pkg.sv
// Shared definitions for the accelerator job controller: register map, bit
// positions, FSM encoding and descriptor sizing.
package accel_job_pkg;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_SRC     = 8'h04;
  localparam logic [7:0] OFF_DST     = 8'h08;
  localparam logic [7:0] OFF_LEN     = 8'h0C;
  localparam logic [7:0] OFF_STATUS  = 8'h10;
  localparam logic [7:0] OFF_IRQ_ACK = 8'h14;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_IRQ     = 4;
  localparam int ST_LVL_LSB = 8;
  localparam int ST_CNT_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  // Descriptor layout is {src, dst, len}, src in the MSBs.
  function automatic int desc_width(input int dw, input int lw);
    return 2 * dw + lw;
  endfunction

endpackage

// File: rtl/job_desc_fifo.sv
// Synchronous descriptor queue with flush; head entry is presented combinationally.
module job_desc_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/accel_job_ctrl.sv
// Register-driven job scheduler: stages descriptors into a queue, issues them
// one at a time over valid/ready, counts completions and raises an interrupt.
module accel_job_ctrl
  import accel_job_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 24,
  parameter int FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] set_addr,
  input  logic [DATA_WIDTH-1:0] set_data,
  input  logic                  set_stb,
  input  logic [DATA_WIDTH-1:0] get_addr,
  output logic [DATA_WIDTH-1:0] get_data,
  input  logic                  get_stb,
  output logic [DATA_WIDTH-1:0] job_src,
  output logic [DATA_WIDTH-1:0] job_dst,
  output logic [LEN_WIDTH-1:0]  job_len,
  output logic                  job_valid,
  input  logic                  job_ready,
  input  logic                  job_done,
  output logic                  irq
);
  localparam int DESC_W = desc_width(DATA_WIDTH, LEN_WIDTH);

  state_e                state_q, state_d;
  logic                  en_q, irq_en_q;
  logic [DATA_WIDTH-1:0] src_q, dst_q, job_src_q, job_dst_q, get_data_q, get_data_d;
  logic [LEN_WIDTH-1:0]  len_q, job_len_q;
  logic                  ovf_q, ovf_d, irq_q, irq_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  wr_ctrl, wr_src, wr_dst, wr_len, wr_ack, soft_clr, pop, done_evt;
  logic [DESC_W-1:0]     push_desc, head_desc;
  logic                  full, empty;
  logic [FIFO_AW:0]      level;
  logic [31:0]           status;
  logic                  unused_ok;

  function automatic logic is_addr(input logic [DATA_WIDTH-1:0] a, input logic [7:0] off);
    return a == DATA_WIDTH'(off);
  endfunction

  assign wr_ctrl   = set_stb && is_addr(set_addr, OFF_CTRL);
  assign wr_src    = set_stb && is_addr(set_addr, OFF_SRC);
  assign wr_dst    = set_stb && is_addr(set_addr, OFF_DST);
  assign wr_len    = set_stb && is_addr(set_addr, OFF_LEN);
  assign wr_ack    = set_stb && is_addr(set_addr, OFF_IRQ_ACK) && set_data[0];
  assign soft_clr  = wr_ctrl && set_data[CTRL_CLR];
  // The LEN write both stages the length and pushes, so the new LEN value goes in directly.
  assign push_desc = {src_q, dst_q, set_data[LEN_WIDTH-1:0]};
  assign unused_ok = get_stb;

  job_desc_fifo #(.W(DESC_W), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_len),
    .pop_i   (pop),
    .flush_i (soft_clr),
    .wdata_i (push_desc),
    .rdata_o (head_desc),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    ovf_d = ovf_q;
    irq_d = irq_q;
    cnt_d = cnt_q;
    if (soft_clr) begin
      ovf_d = 1'b0;
      irq_d = 1'b0;
      cnt_d = '0;
    end else if (wr_len && full) begin
      ovf_d = 1'b1;
    end
    if (wr_ack) irq_d = 1'b0;
    // A completion in the same cycle as an acknowledge must not be lost.
    if (done_evt) begin
      cnt_d = cnt_d + 16'd1;
      if (irq_en_q) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q     <= set_data[CTRL_EN];
        irq_en_q <= set_data[CTRL_IRQ_EN];
      end
      if (wr_src) src_q <= set_data;
      if (wr_dst) dst_q <= set_data;
      if (wr_len) len_q <= set_data[LEN_WIDTH-1:0];
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (en_q && !empty) state_d = S_ISSUE;
      S_ISSUE:     if (job_ready)      state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (job_done)       state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = (state_q == S_IDLE) && en_q && !empty;
    done_evt  = (state_q == S_WAIT_DONE) && job_done;
    job_valid = (state_q == S_ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_src_q <= '0;
      job_dst_q <= '0;
      job_len_q <= '0;
    end else if (pop) begin
      {job_src_q, job_dst_q, job_len_q} <= head_desc;
    end
  end

  always_comb begin
    status                       = '0;
    status[ST_BUSY]              = (state_q != S_IDLE);
    status[ST_FULL]              = full;
    status[ST_EMPTY]             = empty;
    status[ST_OVF]               = ovf_q;
    status[ST_IRQ]               = irq_q;
    status[ST_LVL_LSB +: 8]      = 8'(level);
    status[ST_CNT_LSB +: 16]     = cnt_q;
    get_data_d = '0;
    if      (is_addr(get_addr, OFF_CTRL))   get_data_d = DATA_WIDTH'({irq_en_q, en_q});
    else if (is_addr(get_addr, OFF_SRC))    get_data_d = src_q;
    else if (is_addr(get_addr, OFF_DST))    get_data_d = dst_q;
    else if (is_addr(get_addr, OFF_LEN))    get_data_d = DATA_WIDTH'(len_q);
    else if (is_addr(get_addr, OFF_STATUS)) get_data_d = DATA_WIDTH'(status);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) get_data_q <= '0;
    else     get_data_q <= get_data_d;
  end

  assign get_data = get_data_q;
  assign job_src  = job_src_q;
  assign job_dst  = job_dst_q;
  assign job_len  = job_len_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_accel_job_ctrl.sv
// Directed bench for accel_job_ctrl: register table plus multi-cycle job sequences.
module tb_accel_job_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] set_addr = '0, set_data = '0, get_addr = '0;
  logic        set_stb = 1'b0, get_stb = 1'b0, job_ready = 1'b0, job_done = 1'b0;
  logic [31:0] get_data, job_src, job_dst;
  logic [23:0] job_len;
  logic        job_valid, irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  accel_job_ctrl #(.DATA_WIDTH(32), .LEN_WIDTH(24), .FIFO_AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .set_stb   (set_stb),
    .get_addr  (get_addr),
    .get_data  (get_data),
    .get_stb   (get_stb),
    .job_src   (job_src),
    .job_dst   (job_dst),
    .job_len   (job_len),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_done  (job_done),
    .irq       (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    @(negedge clk);
    set_stb  = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    get_addr = a;
    get_stb  = 1'b1;
    @(negedge clk);
    check(name, get_data, exp);
    get_stb  = 1'b0;
  endtask

  task automatic push_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    wr(32'h04, s);
    wr(32'h08, d);
    wr(32'h0C, l);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (job_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, job_valid}, 32'd1);
  endtask

  task automatic accept(input string name);
    job_ready = 1'b1;
    @(negedge clk);
    job_ready = 1'b0;
    check(name, {31'd0, job_valid}, 32'd0);
  endtask

  task automatic done_pulse();
    job_done = 1'b1;
    @(negedge clk);
    job_done = 1'b0;
  endtask

  task automatic check_job(input string name, input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] l);
    check({name, "_src"}, job_src, s);
    check({name, "_dst"}, job_dst, d);
    check({name, "_len"}, {8'd0, job_len}, l);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    logic ok;

    tbl[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 32'h04, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h08, 32'h12345678, 32'h0};
    tbl[3]  = '{1'b0, 32'h08, 32'h0,        32'h12345678};
    tbl[4]  = '{1'b0, 32'h0C, 32'h0,        32'h00000040};
    tbl[5]  = '{1'b0, 32'h14, 32'h0,        32'h0};
    tbl[6]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{1'b0, 32'h20, 32'h0,        32'h0};
    tbl[8]  = '{1'b0, 32'h00, 32'h0,        32'h00000003};
    tbl[9]  = '{1'b1, 32'h00, 32'h00000002, 32'h0};
    tbl[10] = '{1'b1, 32'h0C, 32'hFF000040, 32'h0};
    tbl[11] = '{1'b0, 32'h0C, 32'h0,        32'h00000040};
    tbl[12] = '{1'b0, 32'h10, 32'h0,        32'h00010100};
    tbl[13] = '{1'b1, 32'h00, 32'h00000006, 32'h0};
    tbl[14] = '{1'b0, 32'h10, 32'h0,        32'h00000004};
    tbl[15] = '{1'b0, 32'h00, 32'h0,        32'h00000002};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_job_valid", {31'd0, job_valid}, 32'd0);
    check_job("rst_job", 32'h0, 32'h0, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_get_data", get_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("rst_status", 32'h10, 32'h00000004);

    // Single job: latency, payload, completion, interrupt
    push_job(32'h1000, 32'h2000, 32'h40);
    wr(32'h00, 32'h3);
    check("lat_n1_valid", {31'd0, job_valid}, 32'd0);
    @(negedge clk);
    check("lat_n2_valid", {31'd0, job_valid}, 32'd1);
    check_job("job1", 32'h1000, 32'h2000, 32'h40);
    accept("job1_accept");
    done_pulse();
    rd_chk("job1_status", 32'h10, 32'h00010014);
    check("job1_irq", {31'd0, irq}, 32'd1);
    wr(32'h14, 32'h1);
    check("job1_irq_ack", {31'd0, irq}, 32'd0);

    // Register map table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
      else              rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // Overflow with enable off, then in-order issue of the first four
    for (int i = 0; i < 5; i++) push_job(32'hA000 + i, 32'hB000 + i, i + 1);
    rd_chk("ovf_status", 32'h10, 32'h0000040A);
    wr(32'h00, 32'h3);
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("ovf_wait%0d", i));
      check_job($sformatf("ovf_job%0d", i), 32'hA000 + i, 32'hB000 + i, i + 1);
      accept($sformatf("ovf_accept%0d", i));
      done_pulse();
    end
    repeat (3) @(negedge clk);
    check("ovf_no_5th", {31'd0, job_valid}, 32'd0);
    rd_chk("ovf_final_status", 32'h10, 32'h0004001C);
    wr(32'h14, 32'h1);

    // Backpressure: hold job stable while enable toggles
    push_job(32'hC0DE0000, 32'hD0D00000, 32'h123);
    wait_valid("hold_wait");
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr(32'h00, (i % 2) ? 32'h3 : 32'h2);
      if (job_valid !== 1'b1 || job_src !== 32'hC0DE0000 || job_dst !== 32'hD0D00000 ||
          job_len !== 24'h123) ok = 1'b0;
    end
    check("hold_stable", {31'd0, ok}, 32'd1);
    accept("hold_accept");
    done_pulse();
    wr(32'h14, 32'h1);

    // Soft clear with three queued and one outstanding
    wr(32'h00, 32'h2);
    for (int i = 0; i < 4; i++) push_job(32'hE000 + i, 32'hF000 + i, 32'h10 + i);
    wr(32'h00, 32'h3);
    wait_valid("clr_wait");
    accept("clr_accept");
    rd_chk("clr_pre_status", 32'h10, 32'h00050309);
    wr(32'h00, 32'h5);
    rd_chk("clr_post_status", 32'h10, 32'h00000005);
    done_pulse();
    rd_chk("clr_done_status", 32'h10, 32'h00010004);
    check("clr_irq", {31'd0, irq}, 32'd0);

    // job_done and IRQ_ACK in the same cycle
    wr(32'h00, 32'h3);
    push_job(32'h5000, 32'h6000, 32'h80);
    wait_valid("race_wait");
    accept("race_accept");
    set_addr = 32'h14;
    set_data = 32'h1;
    set_stb  = 1'b1;
    job_done = 1'b1;
    @(negedge clk);
    set_stb  = 1'b0;
    job_done = 1'b0;
    check("race_irq", {31'd0, irq}, 32'd1);
    rd_chk("race_status", 32'h10, 32'h00020014);

    // Asynchronous reset while waiting for completion
    push_job(32'h7000, 32'h8000, 32'h99);
    wait_valid("arst_wait");
    accept("arst_accept");
    #2 rst = 1'b1;
    #1;
    check_job("arst_job", 32'h0, 32'h0, 32'h0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    check("arst_valid", {31'd0, job_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("arst_status", 32'h10, 32'h00000004);
    repeat (3) @(negedge clk);
    check("arst_idle", {31'd0, job_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
